// File: rtl/rib_dmem_slave_pkg.sv
// ---------------------------------------------------------------------------
// rib_dmem_slave_pkg
// Shared definitions for the RIB data-memory responder:
//   - ZeroWord          : all-zero data word driven on rdata_o outside a read ack
//   - SEL_*             : the legal byte-select patterns for writes
//   - LANE_W / RAM_W    : storage width per byte lane and per word
//   - state_t           : responder FSM states (IDLE / WAIT / RESP)
//   - RIB_REQ           : packed view of one request on the RIB data port
//   - sel_is_legal()    : write byte-select vs. address-offset legality check
// Optional feature: RIB_DMEM_PARITY_EN adds one even-parity bit per byte lane
// (LANE_W = 9, RAM_W = 36). When undefined, LANE_W = 8 and RAM_W = 32.
// ---------------------------------------------------------------------------
package rib_dmem_slave_pkg;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_B0   = 4'b0001;
  localparam logic [3:0] SEL_B1   = 4'b0010;
  localparam logic [3:0] SEL_B2   = 4'b0100;
  localparam logic [3:0] SEL_B3   = 4'b1000;
  localparam logic [3:0] SEL_H0   = 4'b0011;
  localparam logic [3:0] SEL_H1   = 4'b1100;
  localparam logic [3:0] SEL_W    = 4'b1111;

`ifdef RIB_DMEM_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif
  localparam int RAM_W = 4 * LANE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } RIB_REQ;

  // An empty select is accepted (acked, nothing written); every other pattern
  // must be one of the naturally aligned byte/half/word lanes.
  function automatic logic sel_is_legal(input logic [3:0] sel, input logic [1:0] off);
    case (sel)
      SEL_NONE: return 1'b1;
      SEL_B0:   return off == 2'd0;
      SEL_B1:   return off == 2'd1;
      SEL_B2:   return off == 2'd2;
      SEL_B3:   return off == 2'd3;
      SEL_H0:   return off == 2'd0;
      SEL_H1:   return off == 2'd2;
      SEL_W:    return off == 2'd0;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rib_dmem_slave_dmem_sram_array.sv
// ---------------------------------------------------------------------------
// dmem_sram_array
// Single-port synchronous RAM with per-byte-lane write enables and a
// registered read output. Each lane is its own memory so every lane maps onto
// a plain block RAM. Lane width is LANE_W (8, or 9 with RIB_DMEM_PARITY_EN).
// Ports:
//   clk      in   clock, rising edge
//   i_en     in   access enable for this cycle
//   i_we     in   1 = write enabled lanes, 0 = read word into o_rdata
//   i_be     in   per-lane write enables
//   i_addr   in   word address
//   i_wdata  in   write word, RAM_W bits
//   o_rdata  out  registered read word; holds until the next read
// Contents are never reset.
// ---------------------------------------------------------------------------
module dmem_sram_array
  import rib_dmem_slave_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [RAM_W-1:0]  i_wdata,
  output logic [RAM_W-1:0]  o_rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [LANE_W-1:0] r_mem [0:(1<<ADDR_W)-1];
      logic [LANE_W-1:0] r_q;

      always_ff @(posedge clk) begin
        if (i_en) begin
          if (i_we) begin
            if (i_be[gi]) begin
              r_mem[i_addr] <= i_wdata[gi*LANE_W +: LANE_W];
            end
          end else begin
            r_q <= r_mem[i_addr];
          end
        end
      end

      assign o_rdata[gi*LANE_W +: LANE_W] = r_q;
    end
  endgenerate

endmodule

// File: rtl/rib_dmem_slave.sv
// ---------------------------------------------------------------------------
// rib_dmem_slave
// Data-memory responder on the RIB data port. Accepts one request at a time,
// performs byte-enabled writes (committed on the acceptance edge) or returns
// the full unshifted word after WAIT_STATES extra cycles.
// Parameters:
//   ADDR_DEPTH_LOG2  log2 of the word count
//   WAIT_STATES      extra cycles before a read ack (0..15)
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   req_i    in   request valid, held with stable fields until ack_o
//   we_i     in   1 = write, 0 = read
//   addr_i   in   byte address
//   wdata_i  in   write data in its byte lanes
//   sel_i    in   byte-lane enables (writes only)
//   ack_o    out  one-cycle completion pulse
//   rdata_o  out  read word, valid while ack_o on a read
//   err_o    out  error flag, valid while ack_o
//   busy_o   out  request accepted and not yet acknowledged
// Optional feature macro: RIB_DMEM_PARITY_EN (per-lane even parity; a read
// with a bad lane returns the raw word with err_o set).
// ---------------------------------------------------------------------------
module rib_dmem_slave
  import rib_dmem_slave_pkg::*;
#(
  parameter int ADDR_DEPTH_LOG2 = 12,
  parameter int WAIT_STATES     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  sel_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int         AW      = ADDR_DEPTH_LOG2;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic        r_err;
  logic        r_ack;
  logic        r_busy;

  RIB_REQ      w_req;
  logic        w_range_err;
  logic        w_sel_err;
  logic        w_req_err;
  logic        w_accept;
  logic        w_ram_en;
  logic        w_par_err;
  logic        w_rd_ok;
  logic [31:0] w_rd_word;
  logic [RAM_W-1:0] w_ram_wdata;
  logic [RAM_W-1:0] w_ram_rdata;

  assign w_req = '{we: we_i, addr: addr_i, wdata: wdata_i, sel: sel_i};

  // Request checks are evaluated on the raw inputs in the acceptance cycle.
  assign w_range_err = (w_req.addr >> (AW + 2)) != 32'd0;
  assign w_sel_err   = w_req.we && !sel_is_legal(w_req.sel, w_req.addr[1:0]);
  assign w_req_err   = w_range_err || w_sel_err;
  assign w_accept    = (r_state == IDLE) && req_i;

  // Reads are issued straight from the request so the registered RAM output
  // is ready for any wait-state count, including zero. Faulty writes never
  // reach the array.
  assign w_ram_en = w_accept && (!w_req.we || !w_req_err);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_ram_wdata[gi*LANE_W +: 8] = w_req.wdata[gi*8 +: 8];
      assign w_rd_word[gi*8 +: 8]        = w_ram_rdata[gi*LANE_W +: 8];
`ifdef RIB_DMEM_PARITY_EN
      assign w_ram_wdata[gi*LANE_W + 8]  = ^w_req.wdata[gi*8 +: 8];
`endif
    end
  endgenerate

  dmem_sram_array #(
    .ADDR_W (AW)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_req.we),
    .i_be    (w_req.sel),
    .i_addr  (w_req.addr[AW+1:2]),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  // A successful read is one that passed the address check at capture time.
  assign w_rd_ok = r_ack && !r_we && !r_err;

`ifdef RIB_DMEM_PARITY_EN
  logic [3:0] w_lane_bad;
  for (gi = 0; gi < 4; gi++) begin : g_par
    assign w_lane_bad[gi] = ^w_ram_rdata[gi*LANE_W +: LANE_W];
  end
  assign w_par_err = w_rd_ok && (|w_lane_bad);
`else
  assign w_par_err = 1'b0;
`endif

  assign ack_o   = r_ack;
  assign busy_o  = r_busy;
  assign err_o   = r_ack && (r_err || w_par_err);
  assign rdata_o = w_rd_ok ? w_rd_word : ZeroWord;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_i) begin
            r_we   <= we_i;
            r_err  <= w_req_err;
            r_busy <= 1'b1;
            if (we_i || (WAIT_STATES == 0)) begin
              r_state <= RESP;
              r_ack   <= 1'b1;
            end else begin
              r_state <= WAIT;
              r_cnt   <= WS_LOAD;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= RESP;
            r_ack   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
